mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr_picker.sv | 24 ++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and parameter defaults.
package mem_arbiter_pkg;

    localparam int unsigned DEF_WIDTH       = 32;
    localparam int unsigned DEF_MEM_LATENCY = 2;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module rr_picker #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NCORES-1:0] request,
    input  logic [IDX_W-1:0]  last_grant,
    output logic              valid,
    output logic [IDX_W-1:0]  index
);

    // Offsets are scanned from NCORES down to 1 so the nearest successor wins the last write.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            if (request[IDX_W'((32'(last_grant) + NCORES - k) % NCORES)]) begin
                valid = 1'b1;
                index = IDX_W'((32'(last_grant) + NCORES - k) % NCORES);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-core arbiter serialising single read/write transactions onto one synchronous RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NCORES      = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCORES-1:0]       request,
    input  logic [NCORES-1:0]       wren,
    input  logic [NCORES*WIDTH-1:0] address,
    input  logic [NCORES*WIDTH-1:0] writedata,
    output logic [NCORES-1:0]       response,
    output logic [WIDTH-1:0]        readdata,
    output logic [WIDTH-1:0]        mem_address,
    output logic [WIDTH-1:0]        mem_writedata,
    output logic                    mem_wren,
    input  logic [WIDTH-1:0]        mem_readdata,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_idx
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_q;
    logic              wren_q;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_picker #(
        .NCORES (NCORES),
        .IDX_W  (IDX_W)
    ) u_picker (
        .request    (request),
        .last_grant (last_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = wren_q ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The latched address/data registers drive the RAM directly, so they hold between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            grant_q       <= '0;
            last_q        <= IDX_W'(NCORES - 1);
            wren_q        <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            readdata      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q       <= pick_idx;
                        wren_q        <= wren[pick_idx];
                        mem_address   <= address[pick_idx*WIDTH +: WIDTH];
                        mem_writedata <= writedata[pick_idx*WIDTH +: WIDTH];
                    end
                end
                ISSUE: begin
                    if (!wren_q) cnt_q <= CNT_W'(MEM_LATENCY);
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) readdata <= mem_readdata;
                end
                RESP: begin
                    last_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_wren  = (state_q == ISSUE) && wren_q;
    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;
    assign response  = (state_q == RESP) ? (NCORES'(1) << grant_q) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural latency-2 RAM.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   request = '0;
    logic [3:0]   wren = '0;
    logic [127:0] address = '0;
    logic [127:0] writedata = '0;
    logic [3:0]   response;
    logic [31:0]  readdata;
    logic [31:0]  mem_address;
    logic [31:0]  mem_writedata;
    logic         mem_wren;
    logic [31:0]  mem_readdata;
    logic         busy;
    logic [1:0]   grant_idx;

    logic         poke_en = 1'b0;
    logic [9:0]   poke_addr = '0;
    logic [31:0]  poke_data = '0;
    logic [31:0]  ram [0:1023];
    logic [31:0]  pipe [0:LAT-1];

    int n_checks = 0;
    int n_fail = 0;

    mem_arbiter #(
        .WIDTH       (32),
        .NCORES      (4),
        .IDX_W       (2),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (request),
        .wren          (wren),
        .address       (address),
        .writedata     (writedata),
        .response      (response),
        .readdata      (readdata),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_wren      (mem_wren),
        .mem_readdata  (mem_readdata),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_wren) ram[mem_address[9:0]] <= mem_writedata;
        pipe[0] <= ram[mem_address[9:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_readdata = pipe[LAT-1];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Leaves the bench #1 after a posedge with the DUT in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Entered and left #1 after a posedge with the DUT in IDLE; that cycle is cycle 0.
    task automatic do_txn(input int core, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_cyc,
                          input logic [31:0] exp_rd, input string tag);
        int cyc = 0;
        int wcnt = 0;
        int wcyc = -1;
        logic [31:0] waddr = '0;
        logic [31:0] wdat = '0;
        logic [3:0] resp = '0;
        logic done = 1'b0;
        request[core] = 1'b1;
        wren[core] = we;
        address[core*32 +: 32] = addr;
        writedata[core*32 +: 32] = wdata;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (mem_wren) begin
                wcnt++; wcyc = cyc; waddr = mem_address; wdat = mem_writedata;
            end
            if (response != 4'b0) begin
                resp = response;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 1) begin
                    address[core*32 +: 32] = ~addr;
                    writedata[core*32 +: 32] = ~wdata;
                    wren[core] = ~we;
                end
            end
        end
        check_val({tag, "_cycle"}, cyc, exp_cyc);
        check_val({tag, "_resp"}, resp, 4'b1 << core);
        check_val({tag, "_readdata"}, readdata, exp_rd);
        if (we) begin
            check_val({tag, "_wren_cnt"}, wcnt, 1);
            check_val({tag, "_wren_cycle"}, wcyc, 1);
            check_val({tag, "_waddr"}, waddr, addr);
            check_val({tag, "_wdata"}, wdat, wdata);
        end else begin
            check_val({tag, "_no_wren"}, wcnt, 0);
        end
        @(posedge clk); #1;
        request[core] = 1'b0;
        wren[core] = 1'b0;
        @(negedge clk);
        check_val({tag, "_resp_width"}, response, 4'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int idx;
        int wcnt;
        int r0cyc;
        int r1cyc;
        int bad;
        logic [31:0] rd1;

        rst_n = 1'b0;
        poke(10'h010, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) poke(10'(32'h40 + i), 32'h1000 + i);

        @(negedge clk);
        check_val("rst_response", response, 4'b0);
        check_val("rst_mem_wren", mem_wren, 1'b0);
        check_val("rst_mem_address", mem_address, 32'h0);
        check_val("rst_mem_writedata", mem_writedata, 32'h0);
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_grant_idx", grant_idx, 2'd0);
        check_val("rst_busy", busy, 1'b0);

        do_reset();
        do_txn(1, 1'b0, 32'h10, 32'h0, 4, 32'hDEADBEEF, "rd_core1");
        do_txn(2, 1'b1, 32'h20, 32'h55AA, 2, 32'hDEADBEEF, "wr_core2");
        do_txn(2, 1'b0, 32'h20, 32'h0, 4, 32'h55AA, "rdback_core2");

        // All four cores read continuously from reset.
        rst_n = 1'b0;
        request = 4'hF;
        wren = 4'h0;
        for (int i = 0; i < 4; i++) address[i*32 +: 32] = 32'h40 + i;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0; n = 0;
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            if (response != 4'b0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (response[i]) idx = i;
                check_val("rr_onehot", $onehot(response), 1'b1);
                check_val("rr_order", idx, n % 4);
                check_val("rr_cycle", cyc, 4 + 5 * n);
                check_val("rr_readdata", readdata, 32'h1000 + idx);
                n++;
                if (n == 5) request = 4'h0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_val("rr_count", n, 5);

        // Register-dump style: core 0 holds request for 8 writes.
        request[0] = 1'b1; wren[0] = 1'b1;
        address[31:0] = 32'h100; writedata[31:0] = 32'hA0;
        cyc = 0; n = 0; wcnt = 0;
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            if (mem_wren) begin
                check_val("dump_waddr", mem_address, 32'h100 + wcnt);
                check_val("dump_wdata", mem_writedata, 32'hA0 + wcnt);
                wcnt++;
            end
            if (response != 4'b0) begin
                check_val("dump_resp", response, 4'b0001);
                check_val("dump_cycle", cyc, 2 + 3 * n);
                n++;
                if (n < 8) begin
                    address[31:0] = 32'h100 + n;
                    writedata[31:0] = 32'hA0 + n;
                end else begin
                    request[0] = 1'b0; wren[0] = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_val("dump_resp_count", n, 8);
        check_val("dump_wren_count", wcnt, 8);
        check_val("dump_readdata_kept", readdata, 32'h1000);
        check_val("dump_ram_last", ram[10'h107], 32'hA7);

        // Reset during WAIT of a core 3 read.
        request[3] = 1'b1; wren[3] = 1'b0; address[127:96] = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_response", response, 4'b0);
        check_val("midrst_busy", busy, 1'b0);
        check_val("midrst_readdata", readdata, 32'h0);
        check_val("midrst_mem_wren", mem_wren, 1'b0);
        request[3] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("postrst_no_resp", response, 4'b0);
            check_val("postrst_no_wren", mem_wren, 1'b0);
        end
        @(posedge clk); #1;
        do_txn(3, 1'b0, 32'h10, 32'h0, 4, 32'hDEADBEEF, "postrst_rd_core3");

        // Core 0 arrives while core 1 is waiting on the RAM.
        request[1] = 1'b1; wren[1] = 1'b0; address[63:32] = 32'h10;
        cyc = 0; r0cyc = -1; r1cyc = -1; bad = 0; rd1 = '0;
        while (r0cyc < 0 && cyc < 40) begin
            @(negedge clk);
            if (response == 4'b0010) begin
                r1cyc = cyc; rd1 = readdata; request[1] = 1'b0;
            end else if (response == 4'b0001) begin
                r0cyc = cyc; request[0] = 1'b0;
                check_val("late_core0_readdata", readdata, 32'h55AA);
            end else if (response != 4'b0) begin
                bad++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) begin
                request[0] = 1'b1; wren[0] = 1'b0; address[31:0] = 32'h20;
            end
        end
        check_val("late_core1_cycle", r1cyc, 4);
        check_val("late_core1_readdata", rd1, 32'hDEADBEEF);
        check_val("late_core0_cycle", r0cyc, 9);
        check_val("late_bad_resp", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
